// File: rtl/sr_fetch_pkg.sv
// sr_fetch_pkg: shared types and helpers for the schoolRISCV fetch queue.
// Holds the queue entry layout, the PC step and the counter width helper.
package sr_fetch_pkg;

  localparam int unsigned SR_PC_STEP = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Bits needed to hold a count in 0..depth inclusive.
  function automatic int unsigned sr_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sr_fetch_fifo.sv
// sr_fetch_fifo: DEPTH-entry FIFO of fetch_entry_t with flush.
// Pointers wrap naturally because DEPTH is a power of two.
module sr_fetch_fifo
  import sr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = sr_cnt_w(DEPTH),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t  head_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // Next pointer and occupancy values; flush wins over push and pop.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (do_pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/sr_fetch_queue.sv
// sr_fetch_queue: credit-limited fetch front end with flushable queue.
// Optional same-cycle bypass of the queue: define SR_FETCH_BYPASS_EN.
module sr_fetch_queue
  import sr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imReqValid,
  output logic [31:0] imReqAddr,
  input  logic        imRspValid,
  input  logic [31:0] imRspData,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  input  logic        instrReady
);

  localparam int unsigned CW = sr_cnt_w(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   spc_q [DEPTH];
  logic [PW-1:0] sw_q, sr_q;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  logic          fifo_empty;
  fetch_entry_t  push_data;
  logic [CW:0]   used;
  logic          issue;
  logic          rsp_live;
  logic          q_valid;
  logic          push;
  logic          pop;

  assign used      = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign issue     = !rst && !redirectValid && (used < DEPTH_C);
  assign rsp_live  = imRspValid && (drop_q == '0) && !redirectValid;
  assign q_valid   = !fifo_empty;
  assign push_data = '{pc: spc_q[sr_q], instr: imRspData};

  assign imReqValid = issue;
  assign imReqAddr  = fetch_pc_q >> 2;

`ifdef SR_FETCH_BYPASS_EN
  logic byp;
  assign byp        = !rst && rsp_live && fifo_empty;
  assign instrValid = !rst && (q_valid || byp);
  assign instr      = byp ? imRspData : fifo_head.instr;
  assign instrPc    = byp ? spc_q[sr_q] : fifo_head.pc;
  assign push       = rsp_live && !(byp && instrReady);
`else
  assign instrValid = q_valid;
  assign instr      = fifo_head.instr;
  assign instrPc    = fifo_head.pc;
  assign push       = rsp_live;
`endif

  assign pop = q_valid && instrReady && !redirectValid;

  sr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .flush_i (redirectValid),
    .count_o (fifo_count),
    .head_o  (fifo_head),
    .empty_o (fifo_empty)
  );

  // Fetch PC and read accounting; a redirect marks every read still
  // outstanding (already-dropped ones included) as stale.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (redirectValid) begin
      fetch_pc_d = redirectPc;
      inflight_d = inflight_q - CW'(imRspValid);
      drop_d     = inflight_q - CW'(imRspValid);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + SR_PC_STEP;
      inflight_d = inflight_q + CW'(issue) - CW'(imRspValid);
      if (imRspValid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Shadow of issued PCs, popped by every response to stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_q <= '0;
      sr_q <= '0;
      for (int i = 0; i < DEPTH; i++) spc_q[i] <= '0;
    end else begin
      if (issue) begin
        spc_q[sw_q] <= fetch_pc_q;
        sw_q        <= sw_q + 1'b1;
      end
      if (imRspValid) sr_q <= sr_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_sr_fetch_queue.sv
// tb_sr_fetch_queue: scoreboard bench with a fixed-latency memory model.
// Expected stream: fetch restarts at reset/redirect PC, then PC += 4.
module tb_sr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef SR_FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        rst;
  logic        imReqValid;
  logic [31:0] imReqAddr;
  logic        imRspValid;
  logic [31:0] imRspData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrReady;

  sr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imReqValid    (imReqValid),
    .imReqAddr     (imReqAddr),
    .imRspValid    (imRspValid),
    .imRspData     (imRspData),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .instrValid    (instrValid),
    .instr         (instr),
    .instrPc       (instrPc),
    .instrReady    (instrReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          dropped;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    int          rsp;
  } exp_t;

  mreq_t       memq[$];
  exp_t        sb[$];
  int          cyc;
  int          lat;
  int          checks;
  int          failures;
  int          handshakes;
  logic [31:0] model_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  // One clock: memory answers the oldest read when its latency expires.
  task automatic step(input bit rdy, input bit rdir,
                      input logic [31:0] tgt);
    @(posedge clk);
    cyc++;
    #1;
    if (!rst && memq.size() > 0 && memq[0].due == cyc) begin
      imRspValid = 1'b1;
      imRspData  = memword(memq[0].addr);
    end else begin
      imRspValid = 1'b0;
      imRspData  = '0;
    end
    instrReady    = rdy;
    redirectValid = rdir;
    redirectPc    = tgt;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once.
  task automatic do_reset(input int l);
    #2;
    rst           = 1'b1;
    imRspValid    = 1'b0;
    redirectValid = 1'b0;
    #1;
    chk("async_req_valid", imReqValid, 0);
    chk("async_instr_valid", instrValid, 0);
    lat = l;
    step(1, 0, 0);
    step(1, 0, 0);
    rst = 1'b0;
  endtask

  // Monitor: predicts handshake outputs from the scoreboard and memory.
  always @(negedge clk) begin : mon
    int used;
    bit exp_req;
    bit exp_iv;
    if (rst) begin
      chk("rst_req_valid", imReqValid, 0);
      chk("rst_instr_valid", instrValid, 0);
      memq.delete();
      sb.delete();
      model_pc = RESET_PC;
    end else begin
      used = sb.size();
      foreach (memq[i]) if (memq[i].dropped) used++;
      if (imRspValid && memq.size() > 0 && !memq[0].dropped &&
          !redirectValid) begin
        foreach (sb[i]) begin
          if (sb[i].rsp < 0) begin
            sb[i].rsp = cyc;
            break;
          end
        end
      end
      exp_req = !redirectValid && (used < DEPTH);
      chk("req_valid", imReqValid, exp_req);
      if (imReqValid && exp_req)
        chk("req_addr", imReqAddr, model_pc >> 2);
      exp_iv = sb.size() > 0 && sb[0].rsp >= 0 &&
               (sb[0].rsp + (1 - BYP) <= cyc);
      chk("instr_valid", instrValid, exp_iv);
      if (instrValid && exp_iv) begin
        chk("instr_pc", instrPc, sb[0].pc);
        chk("instr_word", instr, sb[0].ins);
        if (instrReady && !redirectValid) begin
          void'(sb.pop_front());
          handshakes++;
        end
      end
      if (imRspValid && memq.size() > 0) void'(memq.pop_front());
      if (imReqValid && exp_req) begin
        memq.push_back('{addr: imReqAddr, due: cyc + lat, dropped: 1'b0});
        sb.push_back('{pc: model_pc, ins: memword(model_pc >> 2), rsp: -1});
        model_pc = model_pc + 32'd4;
      end
      if (redirectValid) begin
        foreach (memq[i]) memq[i].dropped = 1'b1;
        sb.delete();
        model_pc = redirectPc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    imRspValid    = 1'b0;
    imRspData     = '0;
    redirectValid = 1'b0;
    redirectPc    = '0;
    instrReady    = 1'b0;
    cyc           = 0;
    lat           = 2;
    checks        = 0;
    failures      = 0;
    handshakes    = 0;
    model_pc      = RESET_PC;
    step(0, 0, 0);
    chk("reset_instr", instr, 0);
    chk("reset_instr_pc", instrPc, 0);
    do_reset(2);
    // Streaming at latency 2 with decode always ready.
    repeat (30) step(1, 0, 0);
    // Backpressure, then drain.
    repeat (10) step(0, 0, 0);
    repeat (12) step(1, 0, 0);
    // Redirect with three reads in flight at latency 3.
    do_reset(3);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 32'h100);
    repeat (20) step(1, 0, 0);
    // Redirect landing on a response and a pop.
    do_reset(2);
    repeat (12) step(1, 0, 0);
    step(1, 1, 32'h80);
    repeat (15) step(1, 0, 0);
    // Back-to-back redirects.
    step(1, 1, 32'h200);
    step(1, 1, 32'h300);
    repeat (20) step(1, 0, 0);
    // Random latency, backpressure, redirects and resets mid-stream.
    for (int r = 0; r < 6; r++) begin
      do_reset(int'($urandom_range(1, 5)));
      for (int k = 0; k < 150; k++) begin
        step(($urandom % 4) != 0, ($urandom % 20) == 0,
             $urandom & 32'h0000_fffc);
      end
    end
    repeat (2) step(1, 0, 0);
    chk("handshakes_min", 32'(handshakes >= 150), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
